// File: rtl/count_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : count_serializer
//  Description : Frames an 8-bit parallel word (from an upstream counter) into
//                a chip-selected, MSB-first serial stream with a divided serial
//                clock. The receiver samples sdo on the rising edge of sclk.
//
//  Parameters  : CLK_DIV - clk cycles per sclk half-period (1..15)
//
//  Ports       : clk   in   sole clock, rising edge
//                rst   in   asynchronous active-high reset
//                start in   frame request, accepted only while ready=1
//                din   in   [7:0] parallel word, sampled on the accepting edge
//                ready out  high only while idle
//                cs_n  out  frame select, active-low
//                sclk  out  serial clock, idles low
//                sdo   out  serial data, MSB first
//                done  out  one-cycle pulse ending each frame
//
//  Build macro : SER_PARITY_EN - when defined, a ninth even-parity bit (XOR of
//                the eight captured bits) is sent after bit 0.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module count_serializer #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] din,
    output logic       ready,
    output logic       cs_n,
    output logic       sclk,
    output logic       sdo,
    output logic       done
);

`ifdef SER_PARITY_EN
    localparam int N_BITS = 9;
`else
    localparam int N_BITS = 8;
`endif
    localparam int SR_W = N_BITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Divider is always 4 bits so it covers the largest legal CLK_DIV.
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
    localparam logic [3:0] BIT_LOAD = 4'(N_BITS);

    logic [1:0]      state;
    logic [1:0]      state_next;
    logic [3:0]      div_cnt;
    logic [3:0]      bit_cnt;
    logic [SR_W-1:0] shreg;
    logic            sclk_phase;   // 1 during the high half of a bit
    logic            phase_end;
    logic [SR_W-1:0] load_word;

    assign phase_end = (div_cnt == DIV_LAST);

`ifdef SER_PARITY_EN
    assign load_word = {din, ^din};
`else
    assign load_word = din;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_SETUP;
                end
            end
            S_SETUP: begin
                if (phase_end) begin
                    state_next = S_SHIFT;
                end
            end
            S_SHIFT: begin
                // Last low phase of the last bit: counter is about to hit zero.
                if (phase_end && !sclk_phase && (bit_cnt == 4'd1)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: divider, sclk phase, bit counter, shift register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt    <= 4'd0;
            bit_cnt    <= 4'd0;
            shreg      <= '0;
            sclk_phase <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    div_cnt    <= 4'd0;
                    sclk_phase <= 1'b0;
                    if (start) begin
                        shreg   <= load_word;
                        bit_cnt <= BIT_LOAD;
                    end
                end
                S_SETUP: begin
                    if (phase_end) begin
                        div_cnt    <= 4'd0;
                        sclk_phase <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + 4'd1;
                    end
                end
                S_SHIFT: begin
                    if (phase_end) begin
                        div_cnt <= 4'd0;
                        if (sclk_phase) begin
                            sclk_phase <= 1'b0;
                        end else begin
                            // End of a low phase: next bit appears on sdo.
                            // On the final bit the FSM leaves SHIFT, so the
                            // phase must stay low to keep sclk quiet.
                            bit_cnt    <= bit_cnt - 4'd1;
                            shreg      <= {shreg[SR_W-2:0], 1'b0};
                            sclk_phase <= (bit_cnt != 4'd1);
                        end
                    end else begin
                        div_cnt <= div_cnt + 4'd1;
                    end
                end
                default: begin
                    div_cnt    <= 4'd0;
                    bit_cnt    <= 4'd0;
                    shreg      <= '0;
                    sclk_phase <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode (registered state and registered phase only)
    // ------------------------------------------------------------------
    always_comb begin
        ready = 1'b0;
        cs_n  = 1'b1;
        sclk  = 1'b0;
        sdo   = 1'b0;
        done  = 1'b0;
        case (state)
            S_IDLE: begin
                ready = 1'b1;
            end
            S_SETUP: begin
                cs_n = 1'b0;
                sdo  = shreg[SR_W-1];
            end
            S_SHIFT: begin
                cs_n = 1'b0;
                sclk = sclk_phase;
                sdo  = shreg[SR_W-1];
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: doc/count_serializer.md
COUNT_SERIALIZER -- requirements
Module: count_serializer

Interface
REQ-001 Parameter: CLK_DIV, default 2, clk cycles per sclk half-period; legal range 1..15.
REQ-002 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  one clock; reset is asynchronous and active-high.
REQ-004 Port: start  input  1  frame request; accepted only when ready=1.
REQ-005 Port: din  input  8  parallel word from the upstream counter (its q output).
REQ-006 Port: ready  output  1  high only in IDLE.
REQ-007 Port: cs_n  output  1  frame select, active-low.
REQ-008 Port: sclk  output  1  serial clock; idles low; receiver samples sdo on rising edge.
REQ-009 Port: sdo  output  1  serial data, MSB first.
REQ-010 Port: done  output  1  one-cycle pulse at end of frame.

Function
REQ-011 FSM states SHALL be IDLE, SETUP, SHIFT and DONE; all outputs SHALL be registered or decoded only from registered state.
REQ-012 IDLE: ready=1, cs_n=1, sclk=0, sdo=0, done=0; start=1 at an edge (T0) SHALL capture din into the shift register, load bit counter with N, and enter SETUP.
REQ-013 din SHALL be sampled only at T0; later din changes SHALL NOT affect the frame.
REQ-014 SETUP: cs_n=0, sclk=0, sdo=captured bit 7, for CLK_DIV cycles (T0+1..T0+CLK_DIV), then SHIFT.
REQ-015 SHIFT: each bit SHALL occupy 2*CLK_DIV cycles -- sclk=1 for the first CLK_DIV, sclk=0 for the second; sdo SHALL change only at the end of a low phase.
REQ-016 At the end of a low phase, bit counter SHALL decrement; at zero the FSM SHALL enter DONE, otherwise sdo SHALL present the next bit.
REQ-017 cs_n SHALL be low for exactly T0+1..T0+CLK_DIV*(1+2N); exactly N rising sclk edges per frame.
REQ-018 DONE: lasts one cycle (T0+CLK_DIV*(1+2N)+1); done=1, cs_n=1, sclk=0, sdo=0, ready=0; then IDLE, ready=1 the following cycle.
REQ-019 start while ready=0 SHALL be ignored, not queued; start held high continuously SHALL start a new frame on each return to IDLE.
REQ-020 Divider counter SHALL be sized for CLK_DIV=15 and SHALL reset to zero on every phase boundary; no sclk glitches.

Reset
REQ-021 rst=1 SHALL immediately force IDLE: ready=1, cs_n=1, sclk=0, sdo=0, done=0; shift register, bit counter and divider cleared.
REQ-022 rst mid-frame SHALL abort the frame with no done pulse; start SHALL be ignored while rst=1.
REQ-023 First frame after rst deassertion SHALL be accepted on the first edge with rst=0 and start=1.

Configuration
REQ-024 Macro SER_PARITY_EN defined: N=9; ninth bit SHALL be even parity (XOR of the 8 captured bits), sent after bit 0.
REQ-025 Macro SER_PARITY_EN undefined: N=8; no parity logic present; bit counter 4 bits wide in both builds.

Verification
REQ-026 CLK_DIV=2, no parity, din=8'hA5, start pulse at T0 -> sdo bits 1,0,1,0,0,1,0,1 at sclk rises; cs_n low T0+1..T0+34; done high at T0+35 only; ready high at T0+36.
REQ-027 SER_PARITY_EN, CLK_DIV=2, din=8'h07 -> 9 sclk rises, bits 0,0,0,0,0,1,1,1,1; cs_n low T0+1..T0+38; done at T0+39.
REQ-028 start pulsed at T0+10 during the REQ-026 frame with din=8'hFF -> ignored; frame still shifts 8'hA5; single done pulse.
REQ-029 rst asserted at T0+20 of a frame -> same cycle cs_n=1, sclk=0, ready=1; no done pulse; next start after release sends the new din cleanly.
REQ-030 CLK_DIV=1, start held high, din=8'h00 then 8'h80 -> back-to-back frames 19 cycles apart (17 cs_n-low, DONE, IDLE); second frame's first bit 1.
REQ-031 din toggled every cycle after T0 with din=8'h3C at T0 -> serial output is exactly 8'h3C.
